// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - Shared state encoding, default limits and debounce sizing for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  localparam logic [7:0] MAX_READING_DEFAULT = 8'h99;

  function automatic int db_cycles(input int clk_freq, input int debounce_ms);
    return clk_freq / 1000 * debounce_ms;
  endfunction

endpackage

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - Push-button synchroniser, debouncer and single-cycle press pulse generator.
module btn_conditioner
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    pulse_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        pulse_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - Stopwatch control FSM driving the BCD timer and display path.
// Optional lap-hold display freeze is enabled by defining LAP_EN.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int         CLK_FREQ    = 100000000,
  parameter int         DEBOUNCE_MS = 10,
  parameter logic [7:0] MAX_READING = MAX_READING_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  input  logic       btn_lap,
  input  logic [7:0] time_reading,
  output logic       init_regs,
  output logic       count_enabled,
  output logic [7:0] display_reading,
  output logic [1:0] ctrl_state
);

  localparam int DB_CYCLES = db_cycles(CLK_FREQ, DEBOUNCE_MS);

  state_t     state_q, state_d;
  logic       init_q, init_d;
  logic       count_q, count_d;
  logic [7:0] disp_q, disp_d;
  logic       ss_p, clr_p;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_ss (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_start_stop), .pulse_o(ss_p)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_clr (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_clear), .pulse_o(clr_p)
  );

  // Clear dominates start_stop; reaching the limit dominates start_stop in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!clr_p && ss_p) state_d = RUN;
      RUN: begin
        if (clr_p)                             state_d = IDLE;
        else if (time_reading == MAX_READING)  state_d = DONE;
        else if (ss_p)                         state_d = PAUSE;
      end
      PAUSE: begin
        if (clr_p)     state_d = IDLE;
        else if (ss_p) state_d = RUN;
      end
      DONE:    if (clr_p) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    count_d = (state_d == RUN);
    init_d  = (state_d == IDLE) && ((state_q != IDLE) || clr_p);
  end

`ifdef LAP_EN
  logic lap_p;
  logic hold_q, hold_d;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_lap (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_lap), .pulse_o(lap_p)
  );

  // Hold only survives while staying in RUN; the capturing and releasing edges both load the live reading.
  always_comb begin
    hold_d = hold_q;
    if (state_d != RUN)                  hold_d = 1'b0;
    else if (state_q == RUN && lap_p)    hold_d = !hold_q;
    disp_d = (hold_q && hold_d) ? disp_q : time_reading;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= 1'b0;
    else        hold_q <= hold_d;
  end
`else
  wire unused_lap = btn_lap;

  always_comb begin
    disp_d = time_reading;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      init_q  <= 1'b1;
      count_q <= 1'b0;
      disp_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      count_q <= count_d;
      disp_q  <= disp_d;
    end
  end

  assign init_regs       = init_q;
  assign count_enabled   = count_q;
  assign display_reading = disp_q;
  assign ctrl_state      = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - Directed scoreboard bench for stopwatch_ctrl with an 8-cycle debounce.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst_n;
  logic       btn_start_stop;
  logic       btn_clear;
  logic       btn_lap;
  logic [7:0] time_reading;
  logic       init_regs;
  logic       count_enabled;
  logic [7:0] display_reading;
  logic [1:0] ctrl_state;

  int errors = 0;
  int checks = 0;

  logic [11:0] exp_q[$];
  string       tag_q[$];

  localparam logic [1:0] S_IDLE  = 2'b00;
  localparam logic [1:0] S_RUN   = 2'b01;
  localparam logic [1:0] S_PAUSE = 2'b10;
  localparam logic [1:0] S_DONE  = 2'b11;

  stopwatch_ctrl #(
    .CLK_FREQ(8000),
    .DEBOUNCE_MS(1),
    .MAX_READING(8'h99)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_start_stop(btn_start_stop),
    .btn_clear(btn_clear),
    .btn_lap(btn_lap),
    .time_reading(time_reading),
    .init_regs(init_regs),
    .count_enabled(count_enabled),
    .display_reading(display_reading),
    .ctrl_state(ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [1:0] st, input logic init,
                            input logic ce, input logic [7:0] disp);
    exp_q.push_back({st, init, ce, disp});
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [11:0] obs;
    logic [11:0] exp;
    string       tag;
    obs = {ctrl_state, init_regs, count_enabled, display_reading};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: observed %h, no expected entry", obs);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s: observed {st,init,ce,disp}=%h expected %h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    rst_n          = 1'b0;
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    btn_lap        = 1'b0;
    time_reading   = 8'h00;
    step(3);
    expect_out("reset", S_IDLE, 1'b1, 1'b0, 8'h00);
    check_out();

    time_reading = 8'h07;
    rst_n = 1'b1;
    expect_out("release_pre_edge", S_IDLE, 1'b1, 1'b0, 8'h00);
    check_out();
    expect_out("release_first_edge", S_IDLE, 1'b0, 1'b0, 8'h07);
    step(1);
    check_out();

    btn_start_stop = 1'b1;
    expect_out("ss_before_pulse", S_IDLE, 1'b0, 1'b0, 8'h07);
    step(10);
    check_out();
    expect_out("ss_enter_run", S_RUN, 1'b0, 1'b1, 8'h07);
    step(1);
    check_out();
    expect_out("ss_held", S_RUN, 1'b0, 1'b1, 8'h07);
    step(9);
    check_out();
    btn_start_stop = 1'b0;
    expect_out("ss_release", S_RUN, 1'b0, 1'b1, 8'h07);
    step(15);
    check_out();

    time_reading = 8'h23;
    expect_out("display_track", S_RUN, 1'b0, 1'b1, 8'h23);
    step(1);
    check_out();

    for (int i = 0; i < 10; i++) begin
      btn_start_stop = ~btn_start_stop;
      step(3);
    end
    btn_start_stop = 1'b0;
    expect_out("bounce_ignored", S_RUN, 1'b0, 1'b1, 8'h23);
    step(20);
    check_out();

    btn_start_stop = 1'b1;
    expect_out("run_to_pause", S_PAUSE, 1'b0, 1'b0, 8'h23);
    step(11);
    check_out();
    btn_start_stop = 1'b0;
    step(12);

    btn_start_stop = 1'b1;
    btn_clear      = 1'b1;
    expect_out("both_before", S_PAUSE, 1'b0, 1'b0, 8'h23);
    step(10);
    check_out();
    expect_out("both_clear_wins", S_IDLE, 1'b1, 1'b0, 8'h23);
    step(1);
    check_out();
    expect_out("both_init_one_cycle", S_IDLE, 1'b0, 1'b0, 8'h23);
    step(1);
    check_out();
    btn_start_stop = 1'b0;
    btn_clear      = 1'b0;
    expect_out("both_stay_idle", S_IDLE, 1'b0, 1'b0, 8'h23);
    step(12);
    check_out();

    btn_start_stop = 1'b1;
    expect_out("idle_to_run", S_RUN, 1'b0, 1'b1, 8'h23);
    step(11);
    check_out();
    btn_start_stop = 1'b0;
    step(12);
    time_reading = 8'h98;
    expect_out("below_max", S_RUN, 1'b0, 1'b1, 8'h98);
    step(1);
    check_out();
    time_reading = 8'h99;
    expect_out("max_done", S_DONE, 1'b0, 1'b0, 8'h99);
    step(1);
    check_out();

    btn_start_stop = 1'b1;
    expect_out("done_ignores_ss", S_DONE, 1'b0, 1'b0, 8'h99);
    step(11);
    check_out();
    btn_start_stop = 1'b0;
    step(12);

    btn_clear = 1'b1;
    expect_out("done_clear", S_IDLE, 1'b1, 1'b0, 8'h99);
    step(11);
    check_out();
    expect_out("done_clear_init_off", S_IDLE, 1'b0, 1'b0, 8'h99);
    step(1);
    check_out();
    btn_clear = 1'b0;
    step(12);

    btn_clear = 1'b1;
    expect_out("idle_clear_init", S_IDLE, 1'b1, 1'b0, 8'h99);
    step(11);
    check_out();
    expect_out("idle_clear_init_off", S_IDLE, 1'b0, 1'b0, 8'h99);
    step(1);
    check_out();
    btn_clear = 1'b0;
    step(12);

    time_reading = 8'h50;
    btn_start_stop = 1'b1;
    expect_out("run_again", S_RUN, 1'b0, 1'b1, 8'h50);
    step(11);
    check_out();
    btn_start_stop = 1'b0;
    step(12);
    btn_start_stop = 1'b1;
    step(10);
    time_reading = 8'h99;
    expect_out("max_beats_ss", S_DONE, 1'b0, 1'b0, 8'h99);
    step(1);
    check_out();
    btn_start_stop = 1'b0;
    btn_clear = 1'b1;
    step(12);
    btn_clear = 1'b0;
    step(12);

    time_reading = 8'h40;
    btn_start_stop = 1'b1;
    step(11);
    btn_start_stop = 1'b0;
    expect_out("pre_abort_run", S_RUN, 1'b0, 1'b1, 8'h40);
    step(12);
    check_out();
    btn_start_stop = 1'b1;
    step(10);
    rst_n = 1'b0;
    btn_start_stop = 1'b0;
    #1;
    expect_out("async_abort", S_IDLE, 1'b1, 1'b0, 8'h00);
    check_out();
    step(2);
    rst_n = 1'b1;
    expect_out("no_pending_pulse", S_IDLE, 1'b0, 1'b0, 8'h40);
    step(12);
    check_out();

`ifdef LAP_EN
    time_reading = 8'h10;
    btn_start_stop = 1'b1;
    step(11);
    btn_start_stop = 1'b0;
    step(12);
    time_reading = 8'h12;
    step(1);
    btn_lap = 1'b1;
    expect_out("lap_capture", S_RUN, 1'b0, 1'b1, 8'h12);
    step(11);
    check_out();
    time_reading = 8'h15;
    expect_out("lap_hold", S_RUN, 1'b0, 1'b1, 8'h12);
    step(2);
    check_out();
    btn_lap = 1'b0;
    step(12);
    btn_lap = 1'b1;
    expect_out("lap_still_held", S_RUN, 1'b0, 1'b1, 8'h12);
    step(10);
    check_out();
    expect_out("lap_release", S_RUN, 1'b0, 1'b1, 8'h15);
    step(1);
    check_out();
    btn_lap = 1'b0;
    step(12);
`endif

    if (exp_q.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
